// File: rtl/pwr_xnor_lane_pipe_if.sv
// Bundle for the pwr_xnor_lane_pipe cell: input handshake, output
// handshake and the toggle counter side channel.
// The master side feeds words and drives backpressure. The slave side
// is the pipeline itself.
interface pwr_xnor_lane_pipe_if #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [LANES-1:0] in_a;
    logic [LANES-1:0] in_b;
    logic [LANES-1:0] in_c;
    logic [LANES-1:0] in_d;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [LANES-1:0] out_data;
    logic             cnt_clr;
    logic [CNT_W-1:0] toggle_cnt;
    logic             toggle_sat;

    modport master (
        output in_valid, in_a, in_b, in_c, in_d, in_mode, out_ready, cnt_clr,
        input  in_ready, out_valid, out_data, toggle_cnt, toggle_sat
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, in_d, in_mode, out_ready, cnt_clr,
        output in_ready, out_valid, out_data, toggle_cnt, toggle_sat
    );
endinterface

// File: rtl/pwr_xnor_lane_pipe.sv
// pwr_xnor_lane_pipe: computes f = XNOR(XNOR(b,c), ~d & (a|b|c)) on every lane.
// The result is optionally inverted per word. Words flow through a two-stage
// valid/ready pipeline whose bubbles collapse. A saturating counter adds up
// the output bit toggles seen across output transfers.
module pwr_xnor_lane_pipe #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input logic                clk,
    input logic                rst,
    pwr_xnor_lane_pipe_if.slave bus
);
    localparam int PC_W  = $clog2(LANES + 1);
    localparam int SUM_W = (CNT_W + 1 > PC_W) ? CNT_W + 1 : PC_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             r_v1;
    logic [LANES-1:0] r_t1;
    logic [LANES-1:0] r_u1;
    logic             r_mode1;
    logic             r_v2;
    logic [LANES-1:0] r_outData;
    logic [LANES-1:0] r_prevWord;
    logic [CNT_W-1:0] r_toggleCnt;
    logic             r_toggleSat;

    logic             w_en1;
    logic             w_en2;
    logic             w_outXfer;
    logic [LANES-1:0] w_diff;
    logic [PC_W-1:0]  w_delta;
    logic [SUM_W-1:0] w_sum;
    logic             w_sumSat;

    // Each stage may advance when it is empty or when the stage after it
    // is moving. The input side therefore sees room as soon as the tail
    // drains, so a full pipe still accepts a word on the cycle it emits one.
    assign w_en2     = ~r_v2 | bus.out_ready;
    assign w_en1     = ~r_v1 | w_en2;
    assign w_outXfer = r_v2 & bus.out_ready;

    assign bus.in_ready   = w_en1;
    assign bus.out_valid  = r_v2;
    assign bus.out_data   = r_outData;
    assign bus.toggle_cnt = r_toggleCnt;
    assign bus.toggle_sat = r_toggleSat;

    // Stage 1 holds the two partial terms per lane together with the word's
    // polarity. Because in_ready equals the enable, an advance without an
    // incoming word loads a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_t1    <= '0;
            r_u1    <= '0;
            r_mode1 <= 1'b0;
        end else if (w_en1) begin
            r_v1    <= bus.in_valid;
            r_t1    <= ~(bus.in_b ^ bus.in_c);
            r_u1    <= ~bus.in_d & (bus.in_a | bus.in_b | bus.in_c);
            r_mode1 <= bus.in_mode;
        end
    end

    // Stage 2 combines the partial terms and applies the word's own
    // polarity. Data is only replaced by a real word, so out_data stays put
    // across bubbles and stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2      <= 1'b0;
            r_outData <= '0;
        end else if (w_en2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_outData <= ~(r_t1 ^ r_u1) ^ {LANES{r_mode1}};
            end
        end
    end

    // Count the bits that differ from the previously delivered word. The
    // sum is widened before the saturation compare so it can never wrap.
    always_comb begin
        w_diff  = r_outData ^ r_prevWord;
        w_delta = '0;
        for (int i = 0; i < LANES; i++) begin
            w_delta = w_delta + PC_W'(w_diff[i]);
        end
        w_sum    = SUM_W'(r_toggleCnt) + SUM_W'(w_delta);
        w_sumSat = (w_sum >= SUM_W'(CNT_MAX));
    end

    // The last delivered word is kept as the toggle reference. Only reset
    // forgets it; clearing the counter does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prevWord <= '0;
        end else if (w_outXfer) begin
            r_prevWord <= r_outData;
        end
    end

    // The saturating toggle counter with its sticky flag. A clear wins over
    // an increment that lands on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_toggleCnt <= '0;
            r_toggleSat <= 1'b0;
        end else if (bus.cnt_clr) begin
            r_toggleCnt <= '0;
            r_toggleSat <= 1'b0;
        end else if (w_outXfer) begin
            if (w_sumSat) begin
                r_toggleCnt <= CNT_MAX;
                r_toggleSat <= 1'b1;
            end else begin
                r_toggleCnt <= w_sum[CNT_W-1:0];
            end
        end
    end
endmodule
